// File: rtl/lcd_spi_sink.sv
// Write-only 4-wire SPI LCD responder (ST7789-style): decodes commands, tracks the
// CASET/RASET window and power flags, and turns RAMWR data into addressed RGB565 writes.
`timescale 1ns/1ps

module lcd_spi_sink #(
  parameter int ADDR_W = 9,
  parameter int XE_RST = 239,
  parameter int YE_RST = 319
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_dc,
  input  logic              spi_mosi,
  output logic              byte_valid,
  output logic              byte_dc,
  output logic [7:0]        byte_data,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_x,
  output logic [ADDR_W-1:0] fb_y,
  output logic [15:0]       fb_pixel,
  output logic              frame_done,
  output logic              sleep_out,
  output logic              display_on
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CASET = 3'd1;
  localparam logic [2:0] ST_RASET = 3'd2;
  localparam logic [2:0] ST_RAMWR = 3'd3;
  localparam logic [2:0] ST_OTHER = 3'd4;

  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] XE_DEF = ADDR_W'(XE_RST);
  localparam logic [ADDR_W-1:0] YE_DEF = ADDR_W'(YE_RST);

  // Two-flop synchronizer, bit order {sck, cs, dc, mosi}.
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;
  logic       sck_d;
  logic       sck_s;
  logic       cs_s;
  logic       dc_s;
  logic       mosi_s;
  logic       sck_rise;

  assign sck_s    = sync_q2[3];
  assign cs_s     = sync_q2[2];
  assign dc_s     = sync_q2[1];
  assign mosi_s   = sync_q2[0];
  assign sck_rise = sck_s & ~sck_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within or across blocks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 4'b0100;   // chip select parks deasserted
      sync_q2 <= 4'b0100;
      sck_d   <= 1'b0;
    end else begin
      sync_q1 <= {spi_sck, spi_cs, spi_dc, spi_mosi};
      sync_q2 <= sync_q1;
      sck_d   <= sck_s;
    end
  end

  // Bit shifter; a CS deassertion throws away any partial byte.
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic       byte_evt;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt <= 3'd0;
      shift_q <= 7'd0;
    end else if (cs_s) begin
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift_q <= {shift_q[5:0], mosi_s};
    end
  end

  assign byte_evt = sck_rise & ~cs_s & (bit_cnt == 3'd7);
  assign rx_byte  = {shift_q, mosi_s};

  // Command FSM, window registers and pixel address generation.
  logic [2:0]        state_q;
  logic [1:0]        par_idx_q;
  logic [7:0]        par_hi_q;
  logic [ADDR_W-1:0] par_start_q;
  logic [ADDR_W-1:0] par_word;
  logic [ADDR_W-1:0] xs_q;
  logic [ADDR_W-1:0] xe_q;
  logic [ADDR_W-1:0] ys_q;
  logic [ADDR_W-1:0] ye_q;
  logic [ADDR_W-1:0] x_q;
  logic [ADDR_W-1:0] y_q;
  logic              phase_q;
  logic [7:0]        pix_hi_q;
  logic              x_wrap;
  logic              y_wrap;

  assign par_word = ADDR_W'({par_hi_q, rx_byte});
  // Greater-or-equal so that an inverted window (start > end) wraps on every pixel.
  assign x_wrap   = (x_q >= xe_q);
  assign y_wrap   = (y_q >= ye_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_valid  <= 1'b0;
      byte_dc     <= 1'b0;
      byte_data   <= 8'd0;
      fb_we       <= 1'b0;
      fb_x        <= '0;
      fb_y        <= '0;
      fb_pixel    <= 16'd0;
      frame_done  <= 1'b0;
      sleep_out   <= 1'b0;
      display_on  <= 1'b0;
      state_q     <= ST_IDLE;
      par_idx_q   <= 2'd0;
      par_hi_q    <= 8'd0;
      par_start_q <= '0;
      xs_q        <= '0;
      xe_q        <= XE_DEF;
      ys_q        <= '0;
      ye_q        <= YE_DEF;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      pix_hi_q    <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (byte_evt) begin
        byte_valid <= 1'b1;
        byte_dc    <= dc_s;
        byte_data  <= rx_byte;
        if (!dc_s) begin
          // Any command aborts the current state and drops a pending high byte.
          phase_q   <= 1'b0;
          par_idx_q <= 2'd0;
          case (rx_byte)
            8'h2A: state_q <= ST_CASET;
            8'h2B: state_q <= ST_RASET;
            8'h2C: begin
              state_q <= ST_RAMWR;
              x_q     <= xs_q;
              y_q     <= ys_q;
            end
            8'h11: begin sleep_out  <= 1'b1; state_q <= ST_IDLE; end
            8'h10: begin sleep_out  <= 1'b0; state_q <= ST_IDLE; end
            8'h29: begin display_on <= 1'b1; state_q <= ST_IDLE; end
            8'h28: begin display_on <= 1'b0; state_q <= ST_IDLE; end
            default: state_q <= ST_OTHER;
          endcase
        end else begin
          case (state_q)
            ST_CASET, ST_RASET: begin
              par_idx_q <= par_idx_q + 2'd1;
              case (par_idx_q)
                2'd0, 2'd2: par_hi_q <= rx_byte;
                2'd1:       par_start_q <= par_word;
                default: begin
                  if (state_q == ST_CASET) begin
                    xs_q <= par_start_q;
                    xe_q <= par_word;
                  end else begin
                    ys_q <= par_start_q;
                    ye_q <= par_word;
                  end
                  state_q <= ST_IDLE;
                end
              endcase
            end
            ST_RAMWR: begin
              if (!phase_q) begin
                pix_hi_q <= rx_byte;
                phase_q  <= 1'b1;
              end else begin
                fb_we    <= 1'b1;
                fb_x     <= x_q;
                fb_y     <= y_q;
                fb_pixel <= {pix_hi_q, rx_byte};
                phase_q  <= 1'b0;
                if (x_wrap) begin
                  x_q <= xs_q;
                  if (y_wrap) begin
                    y_q        <= ys_q;
                    frame_done <= 1'b1;
                  end else begin
                    y_q <= y_q + ONE;
                  end
                end else begin
                  x_q <= x_q + ONE;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Scoreboard bench for lcd_spi_sink: expected bytes and pixel writes are queued as the
// SPI stream is driven and compared when the DUT strobes byte_valid / fb_we.
`timescale 1ns/1ps

module tb_lcd_spi_sink;

  localparam int ADDR_W = 9;
  localparam int HALF   = 20;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              spi_sck = 1'b0;
  logic              spi_cs = 1'b1;
  logic              spi_dc = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              byte_valid;
  logic              byte_dc;
  logic [7:0]        byte_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_x;
  logic [ADDR_W-1:0] fb_y;
  logic [15:0]       fb_pixel;
  logic              frame_done;
  logic              sleep_out;
  logic              display_on;

  lcd_spi_sink #(.ADDR_W(ADDR_W), .XE_RST(239), .YE_RST(319)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .spi_sck    (spi_sck),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_mosi   (spi_mosi),
    .byte_valid (byte_valid),
    .byte_dc    (byte_dc),
    .byte_data  (byte_data),
    .fb_we      (fb_we),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_pixel   (fb_pixel),
    .frame_done (frame_done),
    .sleep_out  (sleep_out),
    .display_on (display_on)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } exp_byte_t;

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    logic [15:0]       pix;
    logic              fd;
  } exp_pix_t;

  exp_byte_t byte_q[$];
  exp_pix_t  pix_q[$];
  exp_byte_t eb;
  exp_pix_t  ep;
  int        checks = 0;
  int        failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (resetn) begin
      if (byte_valid) begin
        if (byte_q.size() == 0) begin
          check("byte_unexpected", 32'(byte_data), 32'hFFFF_FFFF);
        end else begin
          eb = byte_q.pop_front();
          check("byte_dc", 32'(byte_dc), 32'(eb.dc));
          check("byte_data", 32'(byte_data), 32'(eb.data));
        end
      end
      if (fb_we) begin
        if (pix_q.size() == 0) begin
          check("fb_we_unexpected", 32'(fb_pixel), 32'hFFFF_FFFF);
        end else begin
          ep = pix_q.pop_front();
          check("fb_x", 32'(fb_x), 32'(ep.x));
          check("fb_y", 32'(fb_y), 32'(ep.y));
          check("fb_pixel", 32'(fb_pixel), 32'(ep.pix));
          check("frame_done", 32'(frame_done), 32'(ep.fd));
        end
      end else if (frame_done) begin
        check("frame_done_orphan", 32'(frame_done), 32'd0);
      end
    end
  end

  // Clock out the top n bits of a byte; CS is left low.
  task automatic send_bits(input logic is_data, input logic [7:0] value, input int n);
    spi_cs = 1'b0;
    spi_dc = is_data;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = value[i];
      #HALF spi_sck = 1'b1;
      #HALF spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic is_data, input logic [7:0] value);
    byte_q.push_back('{dc: is_data, data: value});
    send_bits(is_data, value, 8);
    spi_cs = 1'b1;
    #HALF;
  endtask

  task automatic cmd(input logic [7:0] value);
    send_byte(1'b0, value);
  endtask

  task automatic dat(input logic [7:0] value);
    send_byte(1'b1, value);
  endtask

  task automatic params(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    cmd(c);
    dat(s[15:8]); dat(s[7:0]); dat(e[15:8]); dat(e[7:0]);
  endtask

  task automatic pixel(input logic [ADDR_W-1:0] x, input logic [ADDR_W-1:0] y,
                       input logic [15:0] pix, input logic fd);
    pix_q.push_back('{x: x, y: y, pix: pix, fd: fd});
    dat(pix[15:8]);
    dat(pix[7:0]);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    settle();
    check({tag, "_bytes_left"}, 32'(byte_q.size()), 32'd0);
    check({tag, "_pixels_left"}, 32'(pix_q.size()), 32'd0);
    byte_q.delete();
    pix_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
    check({tag, "_fb_x"}, 32'(fb_x), 32'd0);
    check({tag, "_fb_y"}, 32'(fb_y), 32'd0);
    check({tag, "_fb_pixel"}, 32'(fb_pixel), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_sleep_out"}, 32'(sleep_out), 32'd0);
    check({tag, "_display_on"}, 32'(display_on), 32'd0);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #30;
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    #20 resetn = 1'b1;
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Power-up sequence.
    cmd(8'h11);
    settle();
    check("init_sleep_out", 32'(sleep_out), 32'd1);
    check("init_display_off", 32'(display_on), 32'd0);
    cmd(8'h29);
    settle();
    check("init_display_on", 32'(display_on), 32'd1);
    drain("init");

    // Window and three pixels.
    params(8'h2A, 16'h0028, 16'h0117);
    params(8'h2B, 16'h0035, 16'h01BB);
    cmd(8'h2C);
    pixel(9'd40, 9'd53, 16'h0500, 1'b0);
    pixel(9'd41, 9'd53, 16'h0500, 1'b0);
    pixel(9'd42, 9'd53, 16'h0500, 1'b0);
    drain("window");

    // 2x2 window wrap with frame_done on the last pixel.
    params(8'h2A, 16'h0000, 16'h0001);
    params(8'h2B, 16'h0000, 16'h0001);
    cmd(8'h2C);
    pixel(9'd0, 9'd0, 16'hA001, 1'b0);
    pixel(9'd1, 9'd0, 16'hA002, 1'b0);
    pixel(9'd0, 9'd1, 16'hA003, 1'b0);
    pixel(9'd1, 9'd1, 16'hA004, 1'b1);
    pixel(9'd0, 9'd0, 16'hA005, 1'b0);
    drain("wrap");

    // Partial byte discarded by CS deassertion.
    send_bits(1'b0, 8'hFF, 5);
    spi_cs = 1'b1;
    #100;
    cmd(8'h2C);
    pixel(9'd0, 9'd0, 16'h1234, 1'b0);
    drain("cs_abort");

    // Commands drop a pending high byte.
    cmd(8'h2C);
    dat(8'hAA);
    cmd(8'h00);
    dat(8'h55);
    dat(8'h66);
    cmd(8'h2C);
    dat(8'h77);
    cmd(8'h2C);
    pixel(9'd0, 9'd0, 16'h8899, 1'b0);
    drain("pending_drop");

    // Truncated start above end, extra parameter ignored.
    params(8'h2A, 16'hFE05, 16'h0002);
    dat(8'h33);
    params(8'h2B, 16'h0000, 16'h0001);
    cmd(8'h2C);
    pixel(9'd5, 9'd0, 16'hBEEF, 1'b0);
    pixel(9'd5, 9'd1, 16'hCAFE, 1'b1);
    pixel(9'd5, 9'd0, 16'hF00D, 1'b0);
    drain("inverted");

    // Power flags clear; idle data only reported.
    cmd(8'h10);
    cmd(8'h28);
    dat(8'h5A);
    settle();
    check("sleep_in", 32'(sleep_out), 32'd0);
    check("display_off", 32'(display_on), 32'd0);
    drain("flags_off");

    // Reset in the middle of a pixel.
    cmd(8'h11);
    cmd(8'h29);
    cmd(8'h2C);
    dat(8'hDE);
    send_bits(1'b1, 8'hAD, 4);
    settle();
    check("pre_reset_sleep", 32'(sleep_out), 32'd1);
    check("pre_reset_display", 32'(display_on), 32'd1);
    byte_q.delete();
    pix_q.delete();
    resetn = 1'b0;
    #30;
    check_all_zero("mid_reset");
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    #20 resetn = 1'b1;
    settle();
    check("post_reset_fb_we", 32'(fb_we), 32'd0);

    // Row end back at 319: single-column window walks every row.
    params(8'h2A, 16'h0000, 16'h0000);
    cmd(8'h2C);
    for (int i = 0; i <= 320; i++) begin
      pixel('0, ADDR_W'(i % 320), 16'(i * 3 + 1), (i == 319));
    end
    drain("row_sweep");

    // Column end back at 239: single-row window walks every column.
    pulse_reset();
    params(8'h2B, 16'h0000, 16'h0000);
    cmd(8'h2C);
    for (int i = 0; i <= 240; i++) begin
      pixel(ADDR_W'(i % 240), '0, 16'(16'hC000 + i), (i == 239));
    end
    drain("col_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
